// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller and its datapath: FSM states, opcode/funct
// values, ALU codes and mux select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StDecode,
        StExecR,
        StWbR,
        StAddiEx,
        StAddiWb,
        StMemAddr,
        StLwRead,
        StLwWb,
        StSwWr,
        StBeq,
        StJump,
        StExc
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;

    localparam logic [2:0] AluLoad = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluAnd  = 3'b011;

    localparam logic [1:0] MuxBRegB  = 2'b00;
    localparam logic [1:0] MuxBFour  = 2'b01;
    localparam logic [1:0] MuxBImm   = 2'b10;
    localparam logic [1:0] MuxBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcExc    = 2'b11;

    localparam logic [1:0] ExcNone    = 2'b00;
    localparam logic [1:0] ExcOvf     = 2'b01;
    localparam logic [1:0] ExcIllegal = 2'b10;

    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
        logic [2:0] alu;
        case (funct)
            FnAdd:   alu = AluAdd;
            FnSub:   alu = AluSub;
            FnAnd:   alu = AluAnd;
            default: alu = AluLoad;
        endcase
        return alu;
    endfunction

    function automatic logic funct_is_legal(input logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd);
    endfunction

    // Only the signed arithmetic ops can raise an overflow exception.
    function automatic logic funct_traps(input logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: IR fields and ALU flags in, selects and write enables out.
interface mc_ctrl_fsm_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       mux_a_control;
    logic [1:0] mux_b_control;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       mdr_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       epc_write;
    logic [1:0] exc_cause;

    modport master (
        input  opcode, funct, zero, overflow,
        output mux_a_control, mux_b_control, alu_control, pc_source, pc_write, pc_write_cond,
               iord, mem_wr, ir_write, ab_write, alu_out_write, mdr_write, reg_write, reg_dst,
               mem_to_reg, epc_write, exc_cause
    );

    modport slave (
        output opcode, funct, zero, overflow,
        input  mux_a_control, mux_b_control, alu_control, pc_source, pc_write, pc_write_cond,
               iord, mem_wr, ir_write, ab_write, alu_out_write, mdr_write, reg_write, reg_dst,
               mem_to_reg, epc_write, exc_cause
    );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences add/sub/and, addi, lw, sw, beq and j through FETCH..WB and
// raises overflow / illegal-opcode exceptions. Outputs are Moore decodes of state.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);

    localparam int unsigned   CntW    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_WAIT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]      exc_cause_q, exc_cause_d;
    logic            wait_done;

    // Branch outcome is resolved in the datapath via pc_write_cond & zero.
    logic unused_zero;
    assign unused_zero = bus.zero;

    assign wait_done     = (wait_cnt_q == CntLast);
    assign bus.exc_cause = exc_cause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRst;
            wait_cnt_q  <= '0;
            exc_cause_q <= ExcNone;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        exc_cause_d = exc_cause_q;
        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                if (wait_done) state_d = StDecode;
                else           wait_cnt_d = wait_cnt_q + CntW'(1);
            end
            StDecode: begin
                case (bus.opcode)
                    OpRType: begin
                        if (funct_is_legal(bus.funct)) begin
                            state_d = StExecR;
                        end else begin
                            state_d     = StExc;
                            exc_cause_d = ExcIllegal;
                        end
                    end
                    OpAddi:      state_d = StAddiEx;
                    OpLw, OpSw:  state_d = StMemAddr;
                    OpBeq:       state_d = StBeq;
                    OpJ:         state_d = StJump;
                    default: begin
                        state_d     = StExc;
                        exc_cause_d = ExcIllegal;
                    end
                endcase
            end
            StExecR: begin
                if (bus.overflow && funct_traps(bus.funct)) begin
                    state_d     = StExc;
                    exc_cause_d = ExcOvf;
                end else begin
                    state_d = StWbR;
                end
            end
            StAddiEx: begin
                if (bus.overflow) begin
                    state_d     = StExc;
                    exc_cause_d = ExcOvf;
                end else begin
                    state_d = StAddiWb;
                end
            end
            StMemAddr: state_d = (bus.opcode == OpSw) ? StSwWr : StLwRead;
            StLwRead: begin
                if (wait_done) state_d = StLwWb;
                else           wait_cnt_d = wait_cnt_q + CntW'(1);
            end
            StWbR, StAddiWb, StLwWb, StSwWr, StBeq, StJump, StExc: state_d = StFetch;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        bus.mux_a_control = 1'b0;
        bus.mux_b_control = MuxBRegB;
        bus.alu_control   = AluLoad;
        bus.pc_source     = PcSrcAlu;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.ab_write      = 1'b0;
        bus.alu_out_write = 1'b0;
        bus.mdr_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.epc_write     = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus.mux_b_control = MuxBFour;
                bus.alu_control   = AluAdd;
                bus.ir_write      = wait_done;
                bus.pc_write      = wait_done;
            end
            StDecode: begin
                bus.mux_b_control = MuxBImmSh;
                bus.alu_control   = AluAdd;
                bus.ab_write      = 1'b1;
                bus.alu_out_write = 1'b1;
            end
            StExecR: begin
                bus.mux_a_control = 1'b1;
                bus.alu_control   = funct_to_alu(bus.funct);
                bus.alu_out_write = 1'b1;
            end
            StWbR: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            StAddiEx, StMemAddr: begin
                bus.mux_a_control = 1'b1;
                bus.mux_b_control = MuxBImm;
                bus.alu_control   = AluAdd;
                bus.alu_out_write = 1'b1;
            end
            StAddiWb: bus.reg_write = 1'b1;
            StLwRead: begin
                bus.iord      = 1'b1;
                bus.mdr_write = wait_done;
            end
            StLwWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StSwWr: begin
                bus.iord   = 1'b1;
                bus.mem_wr = 1'b1;
            end
            StBeq: begin
                bus.mux_a_control = 1'b1;
                bus.alu_control   = AluSub;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PcSrcAluOut;
            end
            StJump: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PcSrcJump;
            end
            StExc: begin
                bus.epc_write = 1'b1;
                bus.pc_write  = 1'b1;
                bus.pc_source = PcSrcExc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle control-word scoreboard on a MEM_WAIT=2 instance, plus
// lw timing trackers on MEM_WAIT=1 and MEM_WAIT=4 instances.
module tb_mc_ctrl_fsm;

    localparam int MainWait = 2;

    localparam logic [11:0] EPcw    = 12'h800;
    localparam logic [11:0] EPcwc   = 12'h400;
    localparam logic [11:0] EIord   = 12'h200;
    localparam logic [11:0] EMemWr  = 12'h100;
    localparam logic [11:0] EIrW    = 12'h080;
    localparam logic [11:0] EAbW    = 12'h040;
    localparam logic [11:0] EAoW    = 12'h020;
    localparam logic [11:0] EMdrW   = 12'h010;
    localparam logic [11:0] ERegW   = 12'h008;
    localparam logic [11:0] ERegDst = 12'h004;
    localparam logic [11:0] EM2r    = 12'h002;
    localparam logic [11:0] EEpcW   = 12'h001;

    typedef struct packed {
        logic [19:0] w;
        logic [1:0]  c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus ();
    mc_ctrl_fsm_if bus1 ();
    mc_ctrl_fsm_if bus4 ();

    mc_ctrl_fsm #(.MEM_WAIT(2)) u_dut    (.clk(clk), .reset(reset), .bus(bus));
    mc_ctrl_fsm #(.MEM_WAIT(1)) u_dut_w1 (.clk(clk), .reset(reset), .bus(bus1));
    mc_ctrl_fsm #(.MEM_WAIT(4)) u_dut_w4 (.clk(clk), .reset(reset), .bus(bus4));

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       exp_q[$];
    string      cur_tag = "rst";
    logic [1:0] model_cause = 2'b00;
    logic [19:0] dut_w;

    assign dut_w = {bus.mux_a_control, bus.mux_b_control, bus.alu_control, bus.pc_source,
                    bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_wr, bus.ir_write,
                    bus.ab_write, bus.alu_out_write, bus.mdr_write, bus.reg_write, bus.reg_dst,
                    bus.mem_to_reg, bus.epc_write};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [19:0] cw(input logic ma, input logic [1:0] mb, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic [11:0] en);
        return {ma, mb, alu, pcs, en};
    endfunction

    task automatic push(input logic [19:0] w);
        exp_t e;
        e.w = w;
        e.c = model_cause;
        exp_q.push_back(e);
    endtask

    task automatic push_exc(input logic [1:0] cause);
        model_cause = cause;
        push(cw(1'b0, 2'b00, 3'b000, 2'b11, EEpcW | EPcw));
    endtask

    task automatic push_front_end();
        for (int i = 0; i < MainWait - 1; i++) push(cw(1'b0, 2'b01, 3'b001, 2'b00, 12'h000));
        push(cw(1'b0, 2'b01, 3'b001, 2'b00, EIrW | EPcw));
        push(cw(1'b0, 2'b11, 3'b001, 2'b00, EAbW | EAoW));
    endtask

    // Expected cycle-by-cycle control words for one instruction, from FETCH onwards.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov);
        logic [2:0] alu;
        push_front_end();
        case (op)
            6'b100011: begin
                push(cw(1'b1, 2'b10, 3'b001, 2'b00, EAoW));
                for (int i = 0; i < MainWait - 1; i++) push(cw(1'b0, 2'b00, 3'b000, 2'b00, EIord));
                push(cw(1'b0, 2'b00, 3'b000, 2'b00, EIord | EMdrW));
                push(cw(1'b0, 2'b00, 3'b000, 2'b00, ERegW | EM2r));
            end
            6'b101011: begin
                push(cw(1'b1, 2'b10, 3'b001, 2'b00, EAoW));
                push(cw(1'b0, 2'b00, 3'b000, 2'b00, EIord | EMemWr));
            end
            6'b000100: push(cw(1'b1, 2'b00, 3'b010, 2'b01, EPcwc));
            6'b000010: push(cw(1'b0, 2'b00, 3'b000, 2'b10, EPcw));
            6'b001000: begin
                push(cw(1'b1, 2'b10, 3'b001, 2'b00, EAoW));
                if (ov) push_exc(2'b01);
                else    push(cw(1'b0, 2'b00, 3'b000, 2'b00, ERegW));
            end
            6'b000000: begin
                case (fn)
                    6'b100000: alu = 3'b001;
                    6'b100010: alu = 3'b010;
                    6'b100100: alu = 3'b011;
                    default:   alu = 3'b000;
                endcase
                if (alu == 3'b000) begin
                    push_exc(2'b10);
                end else begin
                    push(cw(1'b1, 2'b00, alu, 2'b00, EAoW));
                    if (ov && alu != 3'b011) push_exc(2'b01);
                    else push(cw(1'b0, 2'b00, 3'b000, 2'b00, ERegW | ERegDst));
                end
            end
            default: push_exc(2'b10);
        endcase
    endtask

    // Returns #1 after the posedge following the last scoreboard pop.
    task automatic wait_drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        check_eq({cur_tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic ov);
        cur_tag      = tag;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.zero     = z;
        bus.overflow = ov;
        push_instr(op, fn, ov);
        wait_drain();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({cur_tag, "_ctrl"}, 32'(dut_w), 32'(e.w));
            check_eq({cur_tag, "_cause"}, 32'(bus.exc_cause), 32'(e.c));
        end
    end

    // lw timing on a free-running instance: fetch run = W, ir->mdr = W+2, ir->ir = 3+2W.
    task automatic sweep_step(input string tag, input int w, input logic rst, input logic irw,
                              input logic mdrw, input logic in_fetch, inout int since_ir,
                              inout bit seen_ir, inout int run);
        if (rst) begin
            seen_ir  = 1'b0;
            since_ir = 0;
            run      = 0;
        end else begin
            if (seen_ir) since_ir++;
            if (mdrw && seen_ir) check_eq({tag, "_mdr_off"}, 32'(since_ir), 32'(w + 2));
            if (irw) begin
                if (seen_ir) check_eq({tag, "_lw_lat"}, 32'(since_ir), 32'(3 + 2 * w));
                seen_ir  = 1'b1;
                since_ir = 0;
            end
            if (in_fetch) begin
                run++;
            end else if (run != 0) begin
                check_eq({tag, "_fetch_len"}, 32'(run), 32'(w));
                run = 0;
            end
        end
    endtask

    int s1_since = 0, s4_since = 0, s1_run = 0, s4_run = 0;
    bit s1_seen = 1'b0, s4_seen = 1'b0;

    always @(negedge clk) begin
        sweep_step("w1", 1, reset, bus1.ir_write, bus1.mdr_write, bus1.mux_b_control == 2'b01,
                   s1_since, s1_seen, s1_run);
        sweep_step("w4", 4, reset, bus4.ir_write, bus4.mdr_write, bus4.mux_b_control == 2'b01,
                   s4_since, s4_seen, s4_run);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        logic       ov;
        int         k;
        reset = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.overflow = 1'b0;
        bus1.opcode = 6'b100011; bus1.funct = '0; bus1.zero = 1'b0; bus1.overflow = 1'b0;
        bus4.opcode = 6'b100011; bus4.funct = '0; bus4.zero = 1'b0; bus4.overflow = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_async_ctrl", 32'(dut_w), 32'd0);
        check_eq("rst_async_cause", 32'(bus.exc_cause), 32'd0);
        push(20'h0);
        push(20'h0);
        wait_drain();
        reset = 1'b0;
        cur_tag = "rst_rel";
        push(20'h0);

        do_instr("lw0",      6'b100011, 6'b000000, 1'b0, 1'b0);
        do_instr("beq_z1",   6'b000100, 6'b000000, 1'b1, 1'b0);
        do_instr("beq_z0",   6'b000100, 6'b000000, 1'b0, 1'b0);
        do_instr("add",      6'b000000, 6'b100000, 1'b0, 1'b0);
        do_instr("sub",      6'b000000, 6'b100010, 1'b1, 1'b0);
        do_instr("and_ov",   6'b000000, 6'b100100, 1'b0, 1'b1);
        do_instr("add_ov",   6'b000000, 6'b100000, 1'b0, 1'b1);
        do_instr("addi",     6'b001000, 6'b010101, 1'b0, 1'b0);
        do_instr("addi_ov",  6'b001000, 6'b010101, 1'b0, 1'b1);
        do_instr("illegal",  6'b111111, 6'b000000, 1'b0, 1'b0);
        do_instr("lw_hold",  6'b100011, 6'b000000, 1'b0, 1'b0);
        do_instr("sw",       6'b101011, 6'b000000, 1'b0, 1'b0);
        do_instr("j",        6'b000010, 6'b000000, 1'b0, 1'b0);
        do_instr("bad_fn",   6'b000000, 6'b000001, 1'b0, 1'b0);

        // Reset in the first LW_READ cycle must abort the load with no writes.
        cur_tag = "lw_abort";
        bus.opcode = 6'b100011; bus.funct = '0; bus.overflow = 1'b0;
        push_front_end();
        push(cw(1'b1, 2'b10, 3'b001, 2'b00, EAoW));
        wait_drain();
        check_eq("lw_abort_in_read", 32'(bus.iord), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mid_ctrl", 32'(dut_w), 32'd0);
        check_eq("rst_mid_cause", 32'(bus.exc_cause), 32'd0);
        model_cause = 2'b00;
        cur_tag = "rst_mid";
        push(20'h0);
        push(20'h0);
        wait_drain();
        reset = 1'b0;
        cur_tag = "rst_rel2";
        push(20'h0);
        do_instr("lw_after_rst", 6'b100011, 6'b000000, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            k  = $urandom_range(0, 9);
            ov = 1'($urandom_range(0, 1));
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000100;
                3: op = 6'b000010;
                4: op = 6'b001000;
                5: begin op = 6'b000000; fn = 6'b100000; end
                6: begin op = 6'b000000; fn = 6'b100010; end
                7: begin op = 6'b000000; fn = 6'b100100; end
                8: op = 6'b010000;
                default: op = 6'b000000;
            endcase
            if (op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010) ov = 1'b0;
            do_instr($sformatf("rnd%0d", i), op, fn, 1'($urandom_range(0, 1)), ov);
        end

        repeat (20) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
